hoaa_serial_adder: RTL and testbench
====================================

Name: hoaa_serial_adder

Overview:
- Bit-serial WIDTH-bit approximate adder built around the plus-one (HOAA) cell rule. Shifts operands LSB-first through one approximate/exact cell and feeds each carry back into the next bit.
- The lower APPROX_BITS bits use the plus-one cell equations; the upper bits use an exact full adder.
- An exact reference sum is computed in parallel so that approximation error is flagged per operation.
- Serves as the operand sequencer and result collector directly upstream and downstream of the single-bit cell in area-constrained datapaths.

Parameters:
- WIDTH, 8, operand and result width in bits (>=2).
- APPROX_BITS, 2, number of LSBs using the plus-one cell rule (0..WIDTH; 0 = fully exact).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request a new addition; accepted only when busy=0
- a  input  WIDTH  operand A, sampled on the accept edge
- b  input  WIDTH  operand B, sampled on the accept edge
- cin  input  1  carry into bit 0, sampled on the accept edge
- busy  output  1  high from the accept edge until done is asserted
- done  output  1  one-cycle pulse; sum, cout, exact_sum and err are valid
- sum  output  WIDTH  approximate result
- cout  output  1  approximate carry out of bit WIDTH-1
- exact_sum  output  WIDTH  exact a+b+cin, low WIDTH bits
- err  output  1  high when {cout,sum} != exact {carry,sum}

Behaviour:
- Reset: clk and rst only, synchronous, active-high. Forces state IDLE; busy, done, sum, cout, exact_sum, err all 0; bit index 0; internal shift registers 0.
- States:
  - IDLE: busy=0.
  - SHIFT: busy=1, processes one bit per cycle.
  - Result commit happens on the last SHIFT edge; there is no separate DONE state.
- Accept: at a rising edge with state=IDLE and start=1, latch a, b and cin into both carries (approx and exact). Set idx=0, busy=1, state=SHIFT.
- SHIFT, one bit i=idx per edge:
  - If i < APPROX_BITS: s_i = a_i | ~(b_i ^ c); c_next = b_i | c.
  - Otherwise: s_i = a_i ^ b_i ^ c; c_next = majority(a_i, b_i, c).
  - Exact chain always uses the full-adder equations with its own carry.
  - Shift s_i into the approx result register MSB-side, and the exact bit likewise; increment idx.
- Last bit (idx = WIDTH-1) edge:
  - Load sum, cout (approx carry out), exact_sum and err.
  - Set done=1, busy=0, state=IDLE.
  - Latency: done high exactly WIDTH cycles after the accept edge.
- done is high for exactly one cycle. sum, cout, exact_sum and err hold until the next done or reset.
- start while busy=1 is ignored; no queuing; operands are not re-sampled.
- start held high continuously: next accept occurs on the edge after done (done and busy=0 in the same cycle; IDLE then accepts). Back-to-back throughput is one result per WIDTH+1 cycles.
- Reset mid-operation: aborts with no done pulse. Outputs go to 0 on the reset edge.
- APPROX_BITS=0: sum==exact_sum and err=0 always.
- APPROX_BITS=WIDTH: all bits use the approximate rule.
- idx width is clog2(WIDTH), with a minimum of 1. idx never exceeds WIDTH-1.

Test Plan:
- WIDTH=8, APPROX_BITS=2; a=0x00, b=0x00, cin=0 -> after 8 cycles done=1, sum=0x03, cout=0, exact_sum=0x00, err=1.
- a=0x0F, b=0x01, cin=0 -> sum=0x13, cout=0, exact_sum=0x10, err=1. done exactly 8 cycles after accept; busy high for those 8 cycles.
- a=0xFF, b=0x01, cin=0 -> sum=0x03, cout=1, exact_sum=0x00, err=1.
  - Same operands with APPROX_BITS=0 -> sum=0x00, cout=1, err=0.
- start pulsed again 3 cycles into an operation with a=0x55 -> ignored. The original result is returned and only one done pulse occurs.
  - start held high for 40 cycles -> done pulses every 9 cycles.
- rst asserted 4 cycles into an operation -> next edge: busy=0, done=0, sum=0, no done pulse.
  - A fresh start afterwards yields a correct result.
- Randomized 1000 operations vs a reference model of the bit equations, for APPROX_BITS in {0, 2, 4, 8} -> sum, cout, exact_sum and err match.

Source files
------------

// File: rtl/hoaa_serial_adder.sv
// Bit-serial approximate adder: plus-one cell on the low APPROX_BITS, exact full adder above, exact chain in parallel.
// Result and done land WIDTH cycles after accept; start is ignored while busy (no queuing, no backpressure).
module hoaa_serial_adder #(
    parameter int WIDTH       = 8,
    parameter int APPROX_BITS = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic [WIDTH-1:0] exact_sum,
    output logic             err
);
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state_q;
    logic [IW-1:0]    idx_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic             c_apx_q, c_ex_q;
    logic [WIDTH-1:0] s_apx_q, s_ex_q;
    logic             busy_q, done_q, cout_q, err_q;
    logic [WIDTH-1:0] sum_q, exact_q;

    logic             s_apx, s_ex, c_apx_d, c_ex_d;
    logic [WIDTH-1:0] s_apx_d, s_ex_d;
    logic [31:0]      idx_ext;

    always_comb begin
        idx_ext = 32'(idx_q);
        s_apx   = 1'b0;
        c_apx_d = 1'b0;
        // Plus-one cell: sum bit biased toward 1, carry ignores a entirely.
        if (idx_ext < 32'(APPROX_BITS)) begin
            s_apx   = a_q[0] | ~(b_q[0] ^ c_apx_q);
            c_apx_d = b_q[0] | c_apx_q;
        end else begin
            s_apx   = a_q[0] ^ b_q[0] ^ c_apx_q;
            c_apx_d = (a_q[0] & b_q[0]) | (a_q[0] & c_apx_q) | (b_q[0] & c_apx_q);
        end
        s_ex    = a_q[0] ^ b_q[0] ^ c_ex_q;
        c_ex_d  = (a_q[0] & b_q[0]) | (a_q[0] & c_ex_q) | (b_q[0] & c_ex_q);
        s_apx_d = {s_apx, s_apx_q[WIDTH-1:1]};
        s_ex_d  = {s_ex, s_ex_q[WIDTH-1:1]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            c_apx_q <= 1'b0;
            c_ex_q  <= 1'b0;
            s_apx_q <= '0;
            s_ex_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cout_q  <= 1'b0;
            err_q   <= 1'b0;
            sum_q   <= '0;
            exact_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        c_apx_q <= cin;
                        c_ex_q  <= cin;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    a_q     <= a_q >> 1;
                    b_q     <= b_q >> 1;
                    c_apx_q <= c_apx_d;
                    c_ex_q  <= c_ex_d;
                    s_apx_q <= s_apx_d;
                    s_ex_q  <= s_ex_d;
                    if (idx_q == LAST) begin
                        sum_q   <= s_apx_d;
                        cout_q  <= c_apx_d;
                        exact_q <= s_ex_d;
                        err_q   <= ({c_apx_d, s_apx_d} != {c_ex_d, s_ex_d});
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        idx_q   <= '0;
                        state_q <= IDLE;
                    end else begin
                        idx_q <= idx_q + IW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign exact_sum = exact_q;
    assign err       = err_q;
endmodule

// File: tb/tb_hoaa_serial_adder.sv
// Exercises four adder instances (APPROX_BITS 0, 2, 4, 8) sharing one stimulus stream against a reference model.
module tb_hoaa_serial_adder;
    localparam int W = 8;
    localparam int NI = 4;
    localparam int AP [NI] = '{0, 2, 4, 8};

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0, b = '0;
    logic         cin = 1'b0;

    logic         busy_w [NI];
    logic         done_w [NI];
    logic [W-1:0] sum_w  [NI];
    logic         cout_w [NI];
    logic [W-1:0] ex_w   [NI];
    logic         err_w  [NI];

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        hoaa_serial_adder #(.WIDTH(W), .APPROX_BITS(AP[g])) dut (
            .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
            .busy(busy_w[g]), .done(done_w[g]), .sum(sum_w[g]), .cout(cout_w[g]),
            .exact_sum(ex_w[g]), .err(err_w[g])
        );
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Bit rules evaluated with integer arithmetic; exact reference is a plain sum.
    function automatic void model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mc,
                                  input int ap, output logic [W-1:0] s, output logic co,
                                  output logic [W-1:0] ex, output logic e);
        int c, ai, bi, si, tot;
        c = int'(mc);
        s = '0;
        for (int i = 0; i < W; i++) begin
            ai = int'(ma[i]);
            bi = int'(mb[i]);
            if (i < ap) begin
                si = ((ai + bi + c) % 2 == 0 || ai == 1) ? ((bi == c || ai == 1) ? 1 : 0) : 0;
                c  = (bi + c > 0) ? 1 : 0;
            end else begin
                si = (ai + bi + c) % 2;
                c  = (ai + bi + c) / 2;
            end
            s[i] = si[0];
        end
        co  = c[0];
        tot = int'(ma) + int'(mb) + int'(mc);
        ex  = tot[W-1:0];
        e   = ({co, s} != tot[W:0]);
    endfunction

    task automatic do_op(input logic [W-1:0] oa, input logic [W-1:0] ob, input logic oc, output int lat);
        a = oa; b = ob; cin = oc; start = 1'b1;
        tick();
        start = 1'b0;
        lat = 0;
        while (!done_w[1] && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        for (int g = 0; g < NI; g++) begin
            tests_run++;
            if ({busy_w[g], done_w[g], sum_w[g], cout_w[g], ex_w[g], err_w[g]} !== '0) begin
                tests_failed++;
                $display("FAIL reset[%0d]: busy=%b done=%b sum=%h cout=%b ex=%h err=%b, expected all 0",
                         g, busy_w[g], done_w[g], sum_w[g], cout_w[g], ex_w[g], err_w[g]);
            end
        end
    endtask

    task automatic test_directed();
        logic [W-1:0] va [3] = '{8'h00, 8'h0F, 8'hFF};
        logic [W-1:0] vb [3] = '{8'h00, 8'h01, 8'h01};
        logic [W-1:0] es [3] = '{8'h03, 8'h13, 8'h03};
        logic [W-1:0] ee [3] = '{8'h00, 8'h10, 8'h00};
        logic         ec [3] = '{1'b0, 1'b0, 1'b1};
        int lat, busy_cnt;
        for (int v = 0; v < 3; v++) begin
            a = va[v]; b = vb[v]; cin = 1'b0; start = 1'b1;
            tick();
            start = 1'b0;
            lat = 0; busy_cnt = 0;
            while (!done_w[1] && lat < 20) begin
                if (busy_w[1]) busy_cnt++;
                tick();
                lat++;
            end
            tests_run++;
            if (lat !== 8 || busy_cnt !== 8 || busy_w[1] !== 1'b0) begin
                tests_failed++;
                $display("FAIL latency v%0d: lat=%0d busy_cycles=%0d busy_at_done=%b, expected 8/8/0",
                         v, lat, busy_cnt, busy_w[1]);
            end
            tests_run++;
            if (sum_w[1] !== es[v] || cout_w[1] !== ec[v] || ex_w[1] !== ee[v] || err_w[1] !== 1'b1) begin
                tests_failed++;
                $display("FAIL directed v%0d: sum=%h cout=%b ex=%h err=%b, expected %h %b %h 1",
                         v, sum_w[1], cout_w[1], ex_w[1], err_w[1], es[v], ec[v], ee[v]);
            end
            if (v == 2) begin
                tests_run++;
                if (sum_w[0] !== 8'h00 || cout_w[0] !== 1'b1 || err_w[0] !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL exact_mode: sum=%h cout=%b err=%b, expected 00 1 0",
                             sum_w[0], cout_w[0], err_w[0]);
                end
            end
            tick();
            tests_run++;
            if (done_w[1] !== 1'b0) begin
                tests_failed++;
                $display("FAIL done_width v%0d: done=%b one cycle after pulse, expected 0", v, done_w[1]);
            end
        end
    endtask

    task automatic test_ignore_start();
        int dones = 0;
        logic [W-1:0] got = '0;
        a = 8'h0F; b = 8'h01; cin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        a = 8'h55; start = 1'b1;
        tick();
        start = 1'b0; a = '0; b = '0;
        for (int i = 0; i < 15; i++) begin
            if (done_w[1]) begin
                dones++;
                got = sum_w[1];
            end
            tick();
        end
        tests_run++;
        if (dones !== 1 || got !== 8'h13) begin
            tests_failed++;
            $display("FAIL ignore_start: dones=%0d sum=%h, expected 1 and 13", dones, got);
        end
    endtask

    task automatic test_back_to_back();
        int last = -1, n = 0;
        a = 8'h3C; b = 8'h5A; cin = 1'b1; start = 1'b1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            tick();
            if (done_w[1]) begin
                if (last >= 0) begin
                    tests_run++;
                    if (cyc - last !== 9) begin
                        tests_failed++;
                        $display("FAIL back_to_back: done spacing=%0d, expected 9", cyc - last);
                    end
                end
                last = cyc;
                n++;
            end
        end
        start = 1'b0;
        tests_run++;
        if (n !== 4) begin
            tests_failed++;
            $display("FAIL back_to_back_count: dones=%0d, expected 4", n);
        end
        for (int i = 0; i < 10; i++) tick();
    endtask

    task automatic test_reset_mid();
        int dones = 0, lat;
        logic [W-1:0] s, ex; logic co, e;
        a = 8'hA7; b = 8'h33; cin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tests_run++;
        if (busy_w[1] !== 1'b0 || done_w[1] !== 1'b0 || sum_w[1] !== '0) begin
            tests_failed++;
            $display("FAIL reset_mid: busy=%b done=%b sum=%h, expected 0 0 00", busy_w[1], done_w[1], sum_w[1]);
        end
        for (int i = 0; i < 12; i++) begin
            if (done_w[1]) dones++;
            tick();
        end
        tests_run++;
        if (dones !== 0) begin
            tests_failed++;
            $display("FAIL reset_abort: dones=%0d, expected 0", dones);
        end
        do_op(8'h6E, 8'h91, 1'b1, lat);
        model(8'h6E, 8'h91, 1'b1, 2, s, co, ex, e);
        tests_run++;
        if (lat !== 8 || sum_w[1] !== s || cout_w[1] !== co || ex_w[1] !== ex || err_w[1] !== e) begin
            tests_failed++;
            $display("FAIL after_reset: lat=%0d sum=%h cout=%b ex=%h err=%b, expected 8 %h %b %h %b",
                     lat, sum_w[1], cout_w[1], ex_w[1], err_w[1], s, co, ex, e);
        end
        tick();
    endtask

    task automatic test_random();
        logic [W-1:0] ra, rb, s, ex; logic rc, co, e;
        int lat, reported = 0;
        for (int n = 0; n < 1000; n++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom);
            do_op(ra, rb, rc, lat);
            tests_run++;
            if (lat !== 8) begin
                tests_failed++;
                if (reported++ < 10) $display("FAIL rand_latency op%0d: lat=%0d, expected 8", n, lat);
            end
            for (int g = 0; g < NI; g++) begin
                model(ra, rb, rc, AP[g], s, co, ex, e);
                tests_run++;
                if (sum_w[g] !== s || cout_w[g] !== co || ex_w[g] !== ex || err_w[g] !== e) begin
                    tests_failed++;
                    if (reported++ < 10)
                        $display("FAIL rand ap=%0d a=%h b=%h cin=%b: sum=%h cout=%b ex=%h err=%b, expected %h %b %h %b",
                                 AP[g], ra, rb, rc, sum_w[g], cout_w[g], ex_w[g], err_w[g], s, co, ex, e);
                end
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
